seg_capture: RTL

- Host-side reader for the tinycore 7-segment output.
- Samples uo_out[6:0] plus the decimal point uo_out[7] and waits until each pattern is stable.
- Decodes each stable pattern to a hex nibble and queues the result in a small FIFO for the bench or a host.
- Sits opposite tt_um_tinycore on the dedicated-output bus; it is the receiving end of what the core displays.

---
 rtl/seg_capture_pkg.sv | 26 ++
 rtl/seg_fifo.sv | 79 +++++++
 rtl/seg_capture.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seg_capture_pkg.sv
// Shared types and constants for the 7-segment capture block: glyph table,
// FIFO entry layout and the settle FSM states.
package seg_capture_pkg;

    // All segments and the decimal point dark.
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Index n holds the segment code (a..g on bits 0..6) that displays hex digit n.
    localparam logic [15:0][6:0] SEG_GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic       err;
        logic       dp;
        logic [3:0] digit;
    } seg_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD
    } seg_state_t;

endpackage

// File: rtl/seg_fifo.sv
// Small show-ahead FIFO for decoded digits with a sticky overflow flag and a
// synchronous flush. Storage is a distributed array; the head is gated to zero when empty.
module seg_fifo
    import seg_capture_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       push,
    input  seg_entry_t push_data,
    input  logic       pop,
    output seg_entry_t head,
    output logic       empty,
    output logic       full,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;
    logic        do_push;
    logic        do_pop;
    seg_entry_t  mem_q [DEPTH];

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign overflow = overflow_q;

    // A pop on the same edge frees a slot, so a push into a full FIFO still lands then.
    assign do_pop  = pop && !empty;
    assign do_push = push && !clear && (!full || do_pop);

    assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
            if (push && full && !do_pop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/seg_capture.sv
// Receives the tinycore 7-segment bus, waits for each pattern to hold steady,
// decodes it to a hex nibble and queues it for a reader.
module seg_capture
    import seg_capture_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int DEPTH         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [6:0] seg_in,
    input  logic       dp_in,
    input  logic       clear,
    input  logic       rd_en,
    output logic [3:0] rd_digit,
    output logic       rd_dp,
    output logic       rd_err,
    output logic       fifo_empty,
    output logic       fifo_full,
    output logic       overflow
);

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    logic [7:0]  sync1_q;
    logic [7:0]  s2_q;
    seg_state_t  state_q, state_d;
    logic [7:0]  cur_q, cur_d;
    logic [7:0]  last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        push;
    logic [15:0] glyph_hit;
    seg_entry_t  push_entry;
    seg_entry_t  head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            s2_q    <= '0;
        end else begin
            sync1_q <= {dp_in, seg_in};
            s2_q    <= sync1_q;
        end
    end

    // A pattern is accepted once it has been seen STABLE_CYCLES times after loading cur.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        if (!ena) begin
            state_d = IDLE;
            cur_d   = SEG_BLANK;
            last_d  = SEG_BLANK;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE, HELD: begin
                    if (s2_q != cur_q) begin
                        cur_d   = s2_q;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    if (s2_q != cur_q) begin
                        cur_d = s2_q;
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        if (cur_q == SEG_BLANK) begin
                            last_d  = SEG_BLANK;
                            state_d = IDLE;
                        end else if (cur_q == last_q) begin
                            state_d = HELD;
                        end else begin
                            push    = 1'b1;
                            last_d  = cur_q;
                            state_d = HELD;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_glyph
        assign glyph_hit[gi] = (cur_q[6:0] == SEG_GLYPHS[gi]);
    end

    // Glyph codes are distinct, so at most one hit bit is set.
    always_comb begin
        push_entry.err   = 1'b1;
        push_entry.dp    = cur_q[7];
        push_entry.digit = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (glyph_hit[i]) begin
                push_entry.err   = 1'b0;
                push_entry.digit = 4'(i);
            end
        end
    end

    seg_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (push),
        .push_data (push_entry),
        .pop       (rd_en),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .overflow  (overflow)
    );

    assign rd_digit = head.digit;
    assign rd_dp    = head.dp;
    assign rd_err   = head.err;

endmodule
